pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register; generalises the fixed ID/EX latch to any payload width.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, and flush-to-bubble.
- Adds saturating stall/flush performance counters.
- Instantiated between any two core stages (IF/ID, ID/EX, EX/MEM); the payload is the concatenated stage bundle.

Parameters:
- DATA_W, 32, payload width in bits (>=1)
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- CLEAR_ON_EMPTY, 1, 1 = payload register forced to zero whenever the stage holds no valid entry
- CNT_W, 16, width of each performance counter

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- rdy  input  1  global enable; when low, all state and counters freeze
- flush  input  1  jump/mispredict kill; empties the stage
- in_valid  input  1  upstream entry present
- in_ready  output  1  stage can accept this cycle
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  downstream entry present
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  payload to downstream
- occupancy  output  2  entries held (0..2; max 1 when SKID=0)
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0 (rdy=1)
- flush_cnt  output  CNT_W  flush events that discarded at least one valid entry

Behaviour:
- Reset (rst=0, async): out_valid=0, occupancy=0, out_data=0, skid entry cleared, both counters=0.
  - in_ready=0 during reset; in_ready=1 on the first cycle after release (SKID=1).
- Transfer definitions:
  - Accept = rdy & in_valid & in_ready.
  - Drain = rdy & out_valid & out_ready.
  - Both take effect at the rising edge.
- Latency: an accepted entry appears on out_data/out_valid the next cycle when the stage was empty; 1 cycle minimum.
- SKID=1 states:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE (main valid): in_ready=1, out_valid=1.
  - FULL (main+skid valid): in_ready=0, out_valid=1.
- SKID=1 transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept & !drain -> FULL; the new entry goes to skid.
  - ONE + accept & drain -> ONE; main <= in_data.
  - ONE + drain & !accept -> EMPTY.
  - FULL + drain -> ONE; main <= skid.
  - FULL with no drain holds. Accept is impossible in FULL.
- SKID=1 in_ready is a register output only: no combinational path from out_ready.
- SKID=0:
  - Single entry.
  - in_ready = rdy & (!out_valid | out_ready), combinational.
  - Simultaneous accept and drain replaces the entry.
- rdy=0:
  - in_ready driven 0.
  - No accept or drain.
  - out_valid/out_data hold.
  - Counters hold.
- Flush (rdy=1 & flush=1), highest priority over accept/drain:
  - Next state EMPTY; payload and skid cleared to zero (bubble).
  - A same-cycle input is discarded, not accepted.
  - A same-cycle drain still counts as delivered downstream; downstream owns its own flush.
  - flush_cnt increments if occupancy was nonzero before the edge.
- Flush with rdy=0: ignored.
- CLEAR_ON_EMPTY=1: a transition to EMPTY via drain also zeroes out_data. With 0, out_data keeps the stale value and only out_valid drops.
- Counters:
  - Saturate at all-ones; no wrap.
  - stall_cnt increments when rdy & out_valid & !out_ready & !flush.
- Order (occupancy 2 = FULL): strict FIFO; skid entry never overtakes main.

Decomposition:
- Shared config defines: Enable/Disable, ZeroWord, occupancy encodings OCC_EMPTY/OCC_ONE/OCC_FULL.
- Stage bundle widths (PC, opcode, reg-addr) stay in the shared config so instantiations compute DATA_W from them.
- One sub-module: pipe_sat_counter (CNT_W, increment enable, saturating); instantiated twice.

Test Plan:
- Reset mid-operation:
  - Stimulus: FULL stage with main=0xAAAA_0001, skid=0xAAAA_0002; assert rst low asynchronously between edges.
  - Required: out_valid=0, occupancy=0, out_data=0, counters 0 immediately, without waiting for an edge.
- Back-pressure with SKID=1:
  - Stimulus: out_ready=0; push 0x11, 0x22.
  - Required: occupancy=2, in_ready=0 after 2nd accept, stall_cnt=1 after the 2nd cycle.
  - Then out_ready=1: out_data 0x11 then 0x22, then out_valid=0.
- Full-throughput streaming:
  - Stimulus: in_valid=1, out_ready=1, 8 sequential values 0..7.
  - Required: outputs 0..7 on consecutive cycles after 1-cycle latency; occupancy stays 1; stall_cnt=0.
- Flush collision:
  - Stimulus: FULL stage plus in_valid=1 with 0x99, flush=1, rdy=1.
  - Required next cycle: occupancy=0, out_valid=0, out_data=0, flush_cnt=1; 0x99 never appears.
  - Flush on an empty stage: flush_cnt unchanged.
- rdy freeze:
  - Stimulus: ONE state holding 0x55, out_ready=1, rdy=0 for 3 cycles.
  - Required: out_valid=1, out_data=0x55, in_ready=0, counters unchanged; drains on the first rdy=1 cycle.
- Counter saturation and SKID=0:
  - Stimulus: CNT_W=4, hold a stall for 20 cycles.
  - Required: stall_cnt stops at 15.
  - SKID=0 build: in_ready follows out_ready in the same cycle while occupancy=1.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared configuration for inter-stage pipeline registers: enable levels,
// zero fill, occupancy encodings, stage state type and stage bundle widths.
package pipe_stage_buf_pkg;

    localparam logic ENABLE   = 1'b1;
    localparam logic DISABLE  = 1'b0;
    localparam logic ZERO_BIT = 1'b0;   // replicated to DATA_W to form the zero word

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Stage bundle field widths; instantiations sum these to size DATA_W.
    localparam int PC_W       = 32;
    localparam int OPCODE_W   = 7;
    localparam int REG_ADDR_W = 5;
    localparam int ID_EX_W    = PC_W + OPCODE_W + 3 * REG_ADDR_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    // Map a stage state onto the occupancy count reported to the core.
    function automatic logic [1:0] state_to_occ(input stage_state_t st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = OCC_EMPTY;
            ST_ONE:   occ = OCC_ONE;
            ST_FULL:  occ = OCC_FULL;
            default:  occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);
    import pipe_stage_buf_pkg::*;

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;
    assign o_cnt = r_cnt;

    // Count enabled cycles, holding once every bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((i_en == ENABLE) && !w_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry
// skid buffer, flush-to-bubble and saturating stall/flush counters.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_EMPTY = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [DATA_W-1:0] ZERO_WORD = {DATA_W{ZERO_BIT}};

    stage_state_t      r_state;
    stage_state_t      w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              r_out_valid;
    logic              r_in_ready;
    logic [1:0]        r_occ;
    logic              w_accept;
    logic              w_drain;
    logic              w_stall_en;
    logic              w_flush_en;

    // With the skid buffer in_ready comes only from a register (gated by rdy),
    // so out_ready never reaches upstream combinationally.
    assign in_ready  = rdy & ((SKID == 1) ? r_in_ready : (~r_out_valid | out_ready));
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_occ;

    assign w_accept   = rdy & in_valid & in_ready;
    assign w_drain    = rdy & r_out_valid & out_ready;
    assign w_stall_en = rdy & r_out_valid & ~out_ready & ~flush;
    assign w_flush_en = rdy & flush & (r_occ != OCC_EMPTY);

    // Next-state and payload selection; flush beats accept/drain, rdy=0 freezes.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (!rdy) begin
            w_state_nxt = r_state;
        end else if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = ZERO_WORD;
            w_skid_nxt  = ZERO_WORD;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_nxt = in_data;
                    end else if (w_accept) begin
                        // Only reachable with the skid buffer present.
                        w_state_nxt = ST_FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_nxt  = (CLEAR_ON_EMPTY == 1) ? ZERO_WORD : r_main;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = ZERO_WORD;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = ZERO_WORD;
                    w_skid_nxt  = ZERO_WORD;
                end
            endcase
        end
    end

    // State, payload and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= ZERO_WORD;
            r_skid      <= ZERO_WORD;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_occ       <= OCC_EMPTY;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_occ       <= state_to_occ(w_state_nxt);
        end
    end

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_stall_en),
        .o_cnt (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_flush_en),
        .o_cnt (flush_cnt)
    );

endmodule
